alu_ctrl_fsm: RTL
=================

Name: alu_ctrl_fsm

Overview:
- Multi-cycle control sequencer that drives the 32-bit ALU from the other side of its interface: decodes one MIPS instruction word, issues the 4-bit `aluc` code and operand selects, samples the returned zero/carry/negative/overflow flags, and produces writeback and branch decisions.
- Sits between the instruction fetch/handshake logic and the datapath (register file, operand muxes, ALU).

Parameters:
- RST_AUTO_READY, 1, when 1 `instr_ready` is high in the first cycle after reset; when 0 it stays low until one idle cycle has passed.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous reset, active-high
- instr  in  32  instruction word
- instr_valid  in  1  instruction offered
- instr_ready  out  1  controller can accept
- alu_zero, alu_carry, alu_negative, alu_overflow  in  1 each  ALU flags, valid during EXEC
- aluc  out  4  ALU operation code
- a_sel  out  1  0 = rs, 1 = zero-extended shamt
- b_sel  out  2  0 = rt, 1 = sign-extended imm16, 2 = zero-extended imm16
- imm_out  out  32  extended immediate or shamt per selects
- wb_addr  out  5  destination register (rd for R-type, rt for I-type)
- rf_we  out  1  register-file write enable, one-cycle pulse
- branch_taken  out  1  BEQ/BNE taken, one-cycle pulse
- done  out  1  instruction retired, one-cycle pulse
- illegal  out  1  unsupported encoding, pulse with `done`
- exc_ovf  out  1  signed-overflow exception, pulse with `done`
- busy  out  1  high whenever state is not IDLE

Behaviour:
- Reset: next edge forces state IDLE. All outputs are 0 after reset, except `instr_ready`, which follows RST_AUTO_READY. Reset has priority in any state and aborts the instruction with no `rf_we`/`done`.
- aluc encoding:
  - 0000 ADDU, 0001 SUBU, 0010 ADD, 0011 SUB
  - 0100 AND, 0101 OR, 0110 XOR, 0111 NOR
  - 1000 LUI
  - 1010 SLTU, 1011 SLT
  - 1100 SRA, 1101 SRL, 1110 SLL
  - Shifts: `a` is the amount, `b` is the value.
- FSM: IDLE → DECODE → EXEC → WB → IDLE. Fixed 4-cycle occupancy.
  - IDLE: `instr_ready` = 1. On `instr_valid & instr_ready`, latch `instr` and go to DECODE. Otherwise stay.
  - DECODE: register `aluc`, `a_sel`, `b_sel`, `imm_out`, `wb_addr`, and the illegal/class bits.
  - EXEC: outputs stable. At the end-of-EXEC edge, capture the four flags into internal regs.
  - WB: pulse `done`. Pulse `rf_we` when: writing class, and not illegal, and `wb_addr` != 0, and no overflow trap. Pulse `branch_taken` for BEQ with zero = 1, or BNE with zero = 0. Return to IDLE.
- R-type (op 000000), funct:
  - 100000 ADD, 100001 ADDU, 100010 SUB, 100011 SUBU
  - 100100 AND, 100101 OR, 100110 XOR, 100111 NOR
  - 101010 SLT, 101011 SLTU
  - 000000 SLL, 000010 SRL, 000011 SRA: a_sel = 1
  - 000100 SLLV, 000110 SRLV, 000111 SRAV: a_sel = 0
  - All R-type: b_sel = 0.
- I-type:
  - Sign-extended, b_sel = 1: 001000 ADDI (0010), 001001 ADDIU (0000), 001010 SLTI (1011), 001011 SLTIU (1010).
  - Zero-extended, b_sel = 2: 001100 ANDI, 001101 ORI, 001110 XORI, 001111 LUI (1000).
- Branches: 000100 BEQ and 000101 BNE use SUBU, a_sel = 0, b_sel = 0, no write.
- Any other op/funct: illegal = 1 at WB, no write. `aluc`/selects are held at 0.
- `instr_valid` while busy is ignored; the producer holds it until accepted.
- Instruction 0x00000000 (SLL $0) retires with `rf_we` = 0.

Optional Feature:
- Macro: OVF_TRAP_EN.
- Defined: for ADD, SUB and ADDI with captured overflow = 1, WB suppresses `rf_we` and pulses `exc_ovf` with `done`.
- Undefined: overflow is ignored, the write proceeds, and `exc_ovf` is tied 0.

Test Plan:
- Reset with `instr_valid` = 1 → all outputs 0. With RST_AUTO_READY = 1, accept on the first post-reset cycle and `done` exactly 3 cycles later.
- ADDU $3,$1,$2 (0x00221821) → DECODE gives `aluc` = 0000, a_sel = 0, b_sel = 0, `wb_addr` = 3; WB gives `rf_we` = 1, `done` = 1.
- SLL $4,$5,7 (0x000521C0) → `aluc` = 1110, a_sel = 1, `imm_out` = 7, `wb_addr` = 4.
- BEQ $1,$2,off (0x10220005), flags zero = 1 → `branch_taken` = 1, `rf_we` = 0. Repeat with zero = 0 → `branch_taken` = 0.
- ADDI $2,$1,0x7FFF with overflow = 1 in EXEC → with OVF_TRAP_EN: `exc_ovf` = 1, `rf_we` = 0. Without: `rf_we` = 1, `exc_ovf` = 0.
- Illegal op 0xFC000000 → `illegal` = 1, `done` = 1, `rf_we` = 0. Then `rst` asserted during EXEC of the next instruction → IDLE next cycle, no `done`.

Source files
------------

// File: rtl/alu_ctrl_fsm.sv
// alu_ctrl_fsm: multi-cycle control sequencer for the 32-bit ALU.
// Decodes one MIPS instruction and issues aluc and operand selects.
// It samples the ALU flags and produces writeback/branch decisions.
// Occupancy is a fixed four cycles: IDLE -> DECODE -> EXEC -> WB.
// Optional build macro: OVF_TRAP_EN enables the signed-overflow trap on ADD/SUB/ADDI.
module alu_ctrl_fsm #(
  parameter int RST_AUTO_READY = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr,
  input  logic        instr_valid,
  output logic        instr_ready,
  input  logic        alu_zero,
  input  logic        alu_carry,
  input  logic        alu_negative,
  input  logic        alu_overflow,
  output logic [3:0]  aluc,
  output logic        a_sel,
  output logic [1:0]  b_sel,
  output logic [31:0] imm_out,
  output logic [4:0]  wb_addr,
  output logic        rf_we,
  output logic        branch_taken,
  output logic        done,
  output logic        illegal,
  output logic        exc_ovf,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DECODE, EXEC, WB} state_t;

  state_t      state, state_next;
  logic [31:0] instr_q;
  logic        ready_en;
  logic        accept;
  logic        trap;

  logic [5:0]  op, funct;
  logic [4:0]  rt, rd, shamt;
  logic [15:0] imm16;

  logic [3:0]  dec_aluc;
  logic        dec_a_sel;
  logic [1:0]  dec_b_sel;
  logic [31:0] dec_imm;
  logic [4:0]  dec_wb;
  logic        dec_write, dec_beq, dec_bne, dec_illegal, dec_ovf_op;

  logic        write_q, beq_q, bne_q, illegal_q, ovf_op_q;
  logic        zero_q, carry_q, negative_q, overflow_q;
  logic        unused_ok;

  assign op    = instr_q[31:26];
  assign rt    = instr_q[20:16];
  assign rd    = instr_q[15:11];
  assign shamt = instr_q[10:6];
  assign funct = instr_q[5:0];
  assign imm16 = instr_q[15:0];

  assign instr_ready = (state == IDLE) && ready_en;
  assign accept      = instr_valid && instr_ready;
  assign busy        = (state != IDLE);

`ifdef OVF_TRAP_EN
  assign trap = ovf_op_q && overflow_q;
`else
  assign trap = 1'b0;
`endif

  // rs is consumed by the datapath, not here.
  // Carry and negative are latched for completeness, but no current opcode reads them.
  assign unused_ok = ^{instr_q[25:21], carry_q, negative_q, overflow_q, ovf_op_q};

  // Ready gate: with auto-ready off, the first idle cycle after reset is spent with ready low
  always_ff @(posedge clk) begin
    if (rst) ready_en <= (RST_AUTO_READY != 0);
    else if (state == IDLE) ready_en <= 1'b1;
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // Instruction latch; producer may change instr freely once accepted
  always_ff @(posedge clk) begin
    if (rst)         instr_q <= '0;
    else if (accept) instr_q <= instr;
  end

  // Combinational decode of the latched instruction into ALU controls and class bits
  always_comb begin
    dec_aluc    = 4'b0000;
    dec_a_sel   = 1'b0;
    dec_b_sel   = 2'd0;
    dec_imm     = 32'd0;
    dec_wb      = 5'd0;
    dec_write   = 1'b0;
    dec_beq     = 1'b0;
    dec_bne     = 1'b0;
    dec_illegal = 1'b0;
    dec_ovf_op  = 1'b0;
    case (op)
      6'b000000: begin
        dec_wb    = rd;
        dec_write = 1'b1;
        case (funct)
          6'b100000: begin dec_aluc = 4'b0010; dec_ovf_op = 1'b1; end
          6'b100001: dec_aluc = 4'b0000;
          6'b100010: begin dec_aluc = 4'b0011; dec_ovf_op = 1'b1; end
          6'b100011: dec_aluc = 4'b0001;
          6'b100100: dec_aluc = 4'b0100;
          6'b100101: dec_aluc = 4'b0101;
          6'b100110: dec_aluc = 4'b0110;
          6'b100111: dec_aluc = 4'b0111;
          6'b101010: dec_aluc = 4'b1011;
          6'b101011: dec_aluc = 4'b1010;
          6'b000000: begin dec_aluc = 4'b1110; dec_a_sel = 1'b1; dec_imm = {27'd0, shamt}; end
          6'b000010: begin dec_aluc = 4'b1101; dec_a_sel = 1'b1; dec_imm = {27'd0, shamt}; end
          6'b000011: begin dec_aluc = 4'b1100; dec_a_sel = 1'b1; dec_imm = {27'd0, shamt}; end
          6'b000100: dec_aluc = 4'b1110;
          6'b000110: dec_aluc = 4'b1101;
          6'b000111: dec_aluc = 4'b1100;
          default: begin
            dec_wb      = 5'd0;
            dec_write   = 1'b0;
            dec_illegal = 1'b1;
          end
        endcase
      end
      6'b001000, 6'b001001, 6'b001010, 6'b001011: begin
        dec_b_sel  = 2'd1;
        dec_imm    = {{16{imm16[15]}}, imm16};
        dec_wb     = rt;
        dec_write  = 1'b1;
        case (op[1:0])
          2'b00:   begin dec_aluc = 4'b0010; dec_ovf_op = 1'b1; end
          2'b01:   dec_aluc = 4'b0000;
          2'b10:   dec_aluc = 4'b1011;
          default: dec_aluc = 4'b1010;
        endcase
      end
      6'b001100, 6'b001101, 6'b001110, 6'b001111: begin
        dec_b_sel = 2'd2;
        dec_imm   = {16'd0, imm16};
        dec_wb    = rt;
        dec_write = 1'b1;
        case (op[1:0])
          2'b00:   dec_aluc = 4'b0100;
          2'b01:   dec_aluc = 4'b0101;
          2'b10:   dec_aluc = 4'b0110;
          default: dec_aluc = 4'b1000;
        endcase
      end
      6'b000100: begin dec_aluc = 4'b0001; dec_beq = 1'b1; end
      6'b000101: begin dec_aluc = 4'b0001; dec_bne = 1'b1; end
      default:   dec_illegal = 1'b1;
    endcase
  end

  // Decode results registered during DECODE and held stable through EXEC and WB
  always_ff @(posedge clk) begin
    if (rst) begin
      aluc      <= '0;
      a_sel     <= 1'b0;
      b_sel     <= '0;
      imm_out   <= '0;
      wb_addr   <= '0;
      write_q   <= 1'b0;
      beq_q     <= 1'b0;
      bne_q     <= 1'b0;
      illegal_q <= 1'b0;
      ovf_op_q  <= 1'b0;
    end else if (state == DECODE) begin
      aluc      <= dec_aluc;
      a_sel     <= dec_a_sel;
      b_sel     <= dec_b_sel;
      imm_out   <= dec_imm;
      wb_addr   <= dec_wb;
      write_q   <= dec_write;
      beq_q     <= dec_beq;
      bne_q     <= dec_bne;
      illegal_q <= dec_illegal;
      ovf_op_q  <= dec_ovf_op;
    end
  end

  // ALU flags captured on the edge that ends EXEC
  always_ff @(posedge clk) begin
    if (rst) begin
      zero_q     <= 1'b0;
      carry_q    <= 1'b0;
      negative_q <= 1'b0;
      overflow_q <= 1'b0;
    end else if (state == EXEC) begin
      zero_q     <= alu_zero;
      carry_q    <= alu_carry;
      negative_q <= alu_negative;
      overflow_q <= alu_overflow;
    end
  end

  // Next-state sequencing and WB-cycle pulses
  always_comb begin
    state_next   = state;
    done         = 1'b0;
    rf_we        = 1'b0;
    branch_taken = 1'b0;
    illegal      = 1'b0;
    exc_ovf      = 1'b0;
    case (state)
      IDLE:   if (accept) state_next = DECODE;
      DECODE: state_next = EXEC;
      EXEC:   state_next = WB;
      WB: begin
        state_next   = IDLE;
        done         = 1'b1;
        illegal      = illegal_q;
        exc_ovf      = trap;
        rf_we        = write_q && !illegal_q && (wb_addr != 5'd0) && !trap;
        branch_taken = (beq_q && zero_q) || (bne_q && !zero_q);
      end
      default: state_next = IDLE;
    endcase
  end

endmodule
